clk_div_scheduler: RTL and testbench

Runtime-programmable controller for a bank of clock-divider channels. Each channel produces a 50% divided clock and a one-cycle rising-edge tick. A single config port, with a valid/ready handshake, reprograms any channel's half-period or enable. Changes take effect glitch-free at the channel's next period boundary. Sits beside the fixed dividers and feeds the display scan, audio-decoder serial clock and key-scan logic from one clkin.

---
 rtl/clk_sched_pkg.sv | 12 +
 rtl/clk_sched_channel.sv | 71 +++++++
 rtl/clk_div_scheduler.sv | 54 +++++
 tb/tb_clk_div_scheduler.sv | 254 +++++++++++++++++++++++++
 4 files changed

// File: rtl/clk_sched_pkg.sv
// Shared defaults and channel index names for the divider-channel scheduler.
package clk_sched_pkg;

   localparam int CNT_W_DEF    = 24;
   localparam int DEF_HALF_DEF = 1;

   // Channel assignment on the board: display scan, audio serial clock, key scan.
   localparam int CH_SEG   = 0;
   localparam int CH_AUDIO = 1;
   localparam int CH_KEY   = 2;

endpackage

// File: rtl/clk_sched_channel.sv
// One divider channel: half-period counter, 50% output clock, rising-edge tick,
// and a shadow config that is applied only at a period boundary (or at once
// when the channel is idle) so the output never produces a runt pulse.
module clk_sched_channel
   import clk_sched_pkg::*;
#(
   parameter int CNT_W    = CNT_W_DEF,
   parameter int DEF_HALF = DEF_HALF_DEF
) (
   input  logic             clkin,
   input  logic             rst,
   input  logic             load,
   input  logic [CNT_W-1:0] half,
   input  logic             en,
   output logic             ch_clk,
   output logic             ch_tick,
   output logic             pending
);

   logic [CNT_W-1:0] half_q;
   logic             en_q;
   logic [CNT_W-1:0] cnt_q;
   logic [CNT_W-1:0] sh_half;
   logic             sh_en;
   logic             wrap;
   logic             apply;

   // Compare one bit wider so a half of 2^CNT_W-1 still terminates.
   assign wrap  = ({1'b0, cnt_q} + (CNT_W+1)'(1)) == {1'b0, half_q};

   // Idle channels take new config immediately; running ones wait for the 1->0 edge.
   assign apply = pending && (!en_q || (ch_clk && wrap));

   // Counter, output clock, tick and shadow/pending bookkeeping.
   always_ff @(posedge clkin) begin
      if (rst) begin
         half_q  <= CNT_W'(DEF_HALF);
         en_q    <= 1'b1;
         cnt_q   <= '0;
         sh_half <= CNT_W'(DEF_HALF);
         sh_en   <= 1'b1;
         ch_clk  <= 1'b0;
         ch_tick <= 1'b0;
         pending <= 1'b0;
      end else begin
         ch_tick <= 1'b0;
         if (en_q) begin
            if (wrap) begin
               cnt_q   <= '0;
               ch_clk  <= ~ch_clk;
               ch_tick <= ~ch_clk;
            end else begin
               cnt_q <= cnt_q + CNT_W'(1);
            end
         end
         if (apply) begin
            half_q  <= sh_half;
            en_q    <= sh_en;
            cnt_q   <= '0;
            pending <= 1'b0;
         end
         // The top only strobes load while pending is clear, so it never meets apply.
         if (load) begin
            sh_half <= (half == '0) ? CNT_W'(1) : half;
            sh_en   <= en;
            pending <= 1'b1;
         end
      end
   end

endmodule

// File: rtl/clk_div_scheduler.sv
// Bank of independent divider channels behind a single valid/ready config port.
// A request to a channel with a config still pending is stalled; out-of-range
// channel indices are consumed without effect.
module clk_div_scheduler
   import clk_sched_pkg::*;
#(
   parameter int NUM_CH   = 3,
   parameter int CNT_W    = CNT_W_DEF,
   parameter int DEF_HALF = DEF_HALF_DEF,
   parameter int CH_W     = (NUM_CH > 1) ? $clog2(NUM_CH) : 1
) (
   input  logic              clkin,
   input  logic              rst,
   input  logic              cfg_valid,
   output logic              cfg_ready,
   input  logic [CH_W-1:0]   cfg_ch,
   input  logic [CNT_W-1:0]  cfg_half,
   input  logic              cfg_en,
   output logic [NUM_CH-1:0] ch_clk,
   output logic [NUM_CH-1:0] ch_tick,
   output logic [NUM_CH-1:0] pending
);

   logic [NUM_CH-1:0] ch_sel;
   logic [NUM_CH-1:0] ch_load;

   // One-hot channel decode; an index past the bank selects nothing.
   always_comb begin
      ch_sel = '0;
      for (int i = 0; i < NUM_CH; i++) begin
         ch_sel[i] = (cfg_ch == CH_W'(i));
      end
   end

   assign cfg_ready = ~|(ch_sel & pending);
   assign ch_load   = ch_sel & {NUM_CH{cfg_valid & cfg_ready}};

   for (genvar g = 0; g < NUM_CH; g++) begin : g_ch
      clk_sched_channel #(
         .CNT_W    (CNT_W),
         .DEF_HALF (DEF_HALF)
      ) u_ch (
         .clkin   (clkin),
         .rst     (rst),
         .load    (ch_load[g]),
         .half    (cfg_half),
         .en      (cfg_en),
         .ch_clk  (ch_clk[g]),
         .ch_tick (ch_tick[g]),
         .pending (pending[g])
      );
   end

endmodule

// File: tb/tb_clk_div_scheduler.sv
// Directed bench for clk_div_scheduler with three channels and DEF_HALF=1.
module tb_clk_div_scheduler;
   import clk_sched_pkg::*;

   logic        clkin;
   logic        rst;
   logic        cfg_valid;
   logic        cfg_ready;
   logic [1:0]  cfg_ch;
   logic [23:0] cfg_half;
   logic        cfg_en;
   logic [2:0]  ch_clk;
   logic [2:0]  ch_tick;
   logic [2:0]  pending;

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   clk_div_scheduler #(
      .NUM_CH   (3),
      .CNT_W    (24),
      .DEF_HALF (1)
   ) dut (
      .clkin     (clkin),
      .rst       (rst),
      .cfg_valid (cfg_valid),
      .cfg_ready (cfg_ready),
      .cfg_ch    (cfg_ch),
      .cfg_half  (cfg_half),
      .cfg_en    (cfg_en),
      .ch_clk    (ch_clk),
      .ch_tick   (ch_tick),
      .pending   (pending)
   );

   initial begin
      clkin = 1'b0;
      forever #5 clkin = ~clkin;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, got timeout, required finish");
      $fatal(1);
   end

   task automatic step();
      @(posedge clkin);
      #1;
      cyc++;
   endtask

   task automatic test_reset();
      rst = 1'b1; cfg_valid = 1'b0; cfg_ch = 2'd0; cfg_half = 24'd0; cfg_en = 1'b0;
      step();
      step();
      n_checks++;
      if (ch_clk !== 3'b000 || ch_tick !== 3'b000 || pending !== 3'b000) begin
         n_fail++;
         $display("FAIL reset_outputs: clk=%b tick=%b pend=%b, required all 000", ch_clk, ch_tick, pending);
      end
      n_checks++;
      if (cfg_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_ready: got %b, required 1", cfg_ready);
      end
      rst = 1'b0;
      cyc = 0;
      for (int i = 0; i < 6; i++) begin
         step();
         n_checks++;
         if (ch_clk !== (cyc[0] ? 3'b111 : 3'b000) || ch_tick !== (cyc[0] ? 3'b111 : 3'b000)) begin
            n_fail++;
            $display("FAIL default_div cyc=%0d: clk=%b tick=%b, required %b", cyc, ch_clk, ch_tick,
                     cyc[0] ? 3'b111 : 3'b000);
         end
         n_checks++;
         if (pending !== 3'b000 || cfg_ready !== 1'b1) begin
            n_fail++;
            $display("FAIL default_idle cyc=%0d: pend=%b ready=%b, required 000/1", cyc, pending, cfg_ready);
         end
      end
   endtask

   // ch0 half 1 -> 4 applied at the next 1->0 edge; cycles 7..20
   task automatic test_period_change();
      logic [0:13] e_clk  = 14'b10000111100001;
      logic [0:13] e_tick = 14'b10000100000001;
      logic [0:13] e_pend = 14'b10000000000000;
      cfg_ch = 2'(CH_SEG); cfg_half = 24'd4; cfg_en = 1'b1; cfg_valid = 1'b1;
      n_checks++;
      if (cfg_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL period_ready_pre: got %b, required 1", cfg_ready);
      end
      for (int i = 0; i < 14; i++) begin
         step();
         cfg_valid = 1'b0;
         n_checks++;
         if (ch_clk[0] !== e_clk[i] || ch_tick[0] !== e_tick[i] || pending[0] !== e_pend[i]) begin
            n_fail++;
            $display("FAIL period_ch0 cyc=%0d: clk=%b tick=%b pend=%b, required %b %b %b", cyc,
                     ch_clk[0], ch_tick[0], pending[0], e_clk[i], e_tick[i], e_pend[i]);
         end
         n_checks++;
         if (cfg_ready !== !e_pend[i]) begin
            n_fail++;
            $display("FAIL period_ready cyc=%0d: got %b, required %b", cyc, cfg_ready, !e_pend[i]);
         end
         n_checks++;
         if (ch_clk[2:1] !== (cyc[0] ? 2'b11 : 2'b00)) begin
            n_fail++;
            $display("FAIL period_others cyc=%0d: got %b, required %b", cyc, ch_clk[2:1], cyc[0] ? 2'b11 : 2'b00);
         end
      end
   endtask

   // second ch0 request stalls while the first is pending; cycles 21..30
   task automatic test_back_to_back();
      logic [0:9] e_clk   = 10'b1110011010;
      logic [0:9] e_pend  = 10'b1110111000;
      logic [0:9] e_ready = 10'b0001000111;
      logic [0:9] e_tick  = 10'b0000010010;
      cfg_ch = 2'(CH_SEG); cfg_half = 24'd2; cfg_en = 1'b1; cfg_valid = 1'b1;
      for (int i = 0; i < 10; i++) begin
         step();
         if (cyc == 21) cfg_half = 24'd1;
         if (cyc == 25) cfg_valid = 1'b0;
         n_checks++;
         if (ch_clk[0] !== e_clk[i] || ch_tick[0] !== e_tick[i] || pending[0] !== e_pend[i]) begin
            n_fail++;
            $display("FAIL b2b_ch0 cyc=%0d: clk=%b tick=%b pend=%b, required %b %b %b", cyc,
                     ch_clk[0], ch_tick[0], pending[0], e_clk[i], e_tick[i], e_pend[i]);
         end
         n_checks++;
         if (cfg_ready !== e_ready[i]) begin
            n_fail++;
            $display("FAIL b2b_ready cyc=%0d: got %b, required %b", cyc, cfg_ready, e_ready[i]);
         end
         n_checks++;
         if (ch_clk[2:1] !== (cyc[0] ? 2'b11 : 2'b00)) begin
            n_fail++;
            $display("FAIL b2b_others cyc=%0d: got %b, required %b", cyc, ch_clk[2:1], cyc[0] ? 2'b11 : 2'b00);
         end
      end
   endtask

   // ch1 disabled at its boundary, then re-enabled with half 3; cycles 31..43
   task automatic test_disable_enable();
      logic [0:12] e_clk  = 13'b1000001110001;
      logic [0:12] e_pend = 13'b1010000000000;
      logic [0:12] e_tick = 13'b1000001000001;
      cfg_ch = 2'(CH_AUDIO); cfg_half = 24'd3; cfg_en = 1'b0; cfg_valid = 1'b1;
      for (int i = 0; i < 13; i++) begin
         step();
         if (cyc == 31) cfg_valid = 1'b0;
         if (cyc == 32) begin cfg_valid = 1'b1; cfg_en = 1'b1; end
         if (cyc == 33) cfg_valid = 1'b0;
         n_checks++;
         if (ch_clk[1] !== e_clk[i] || ch_tick[1] !== e_tick[i] || pending[1] !== e_pend[i]) begin
            n_fail++;
            $display("FAIL dis_en_ch1 cyc=%0d: clk=%b tick=%b pend=%b, required %b %b %b", cyc,
                     ch_clk[1], ch_tick[1], pending[1], e_clk[i], e_tick[i], e_pend[i]);
         end
         n_checks++;
         if (cfg_ready !== !e_pend[i]) begin
            n_fail++;
            $display("FAIL dis_en_ready cyc=%0d: got %b, required %b", cyc, cfg_ready, !e_pend[i]);
         end
         n_checks++;
         if ({ch_clk[2], ch_clk[0]} !== (cyc[0] ? 2'b11 : 2'b00)) begin
            n_fail++;
            $display("FAIL dis_en_others cyc=%0d: got %b, required %b", cyc, {ch_clk[2], ch_clk[0]},
                     cyc[0] ? 2'b11 : 2'b00);
         end
      end
   endtask

   // half 0 to ch2 acts as half 1; index 3 is consumed silently; cycles 44..50
   task automatic test_zero_and_range();
      logic [0:6] e_clk2 = 7'b0101010;
      logic [0:6] e_clk1 = 7'b1100011;
      logic [0:6] e_pd2  = 7'b1100000;
      cfg_ch = 2'(CH_KEY); cfg_half = 24'd0; cfg_en = 1'b1; cfg_valid = 1'b1;
      for (int i = 0; i < 7; i++) begin
         step();
         if (cyc == 44) cfg_valid = 1'b0;
         if (cyc == 46) begin
            cfg_ch = 2'd3; cfg_half = 24'd7; cfg_en = 1'b0; cfg_valid = 1'b1;
            n_checks++;
            if (cfg_ready !== 1'b1) begin
               n_fail++;
               $display("FAIL range_ready: got %b, required 1", cfg_ready);
            end
         end
         if (cyc == 47) begin cfg_valid = 1'b0; cfg_ch = 2'd0; end
         n_checks++;
         if (ch_clk !== {e_clk2[i], e_clk1[i], cyc[0]}) begin
            n_fail++;
            $display("FAIL zero_range_clk cyc=%0d: got %b, required %b", cyc, ch_clk, {e_clk2[i], e_clk1[i], cyc[0]});
         end
         n_checks++;
         if (pending !== {e_pd2[i], 2'b00}) begin
            n_fail++;
            $display("FAIL zero_range_pend cyc=%0d: got %b, required %b", cyc, pending, {e_pd2[i], 2'b00});
         end
      end
   endtask

   // reset while ch0 is high with a pending shadow; shadow must be discarded
   task automatic test_reset_pending();
      cfg_ch = 2'(CH_SEG); cfg_half = 24'd6; cfg_en = 1'b1; cfg_valid = 1'b1;
      step();
      cfg_valid = 1'b0;
      n_checks++;
      if (pending !== 3'b001 || ch_clk[0] !== 1'b1) begin
         n_fail++;
         $display("FAIL rst_pend_setup: pend=%b clk0=%b, required 001/1", pending, ch_clk[0]);
      end
      rst = 1'b1;
      step();
      n_checks++;
      if (ch_clk !== 3'b000 || ch_tick !== 3'b000 || pending !== 3'b000 || cfg_ready !== 1'b1) begin
         n_fail++;
         $display("FAIL rst_pend_clear: clk=%b tick=%b pend=%b ready=%b, required 000/000/000/1",
                  ch_clk, ch_tick, pending, cfg_ready);
      end
      rst = 1'b0;
      cyc = 0;
      for (int i = 0; i < 4; i++) begin
         step();
         n_checks++;
         if (ch_clk !== (cyc[0] ? 3'b111 : 3'b000) || ch_tick !== (cyc[0] ? 3'b111 : 3'b000)
             || pending !== 3'b000) begin
            n_fail++;
            $display("FAIL rst_pend_after cyc=%0d: clk=%b tick=%b pend=%b, required clk/tick %b pend 000",
                     cyc, ch_clk, ch_tick, pending, cyc[0] ? 3'b111 : 3'b000);
         end
      end
   endtask

   initial begin
      test_reset();
      test_period_change();
      test_back_to_back();
      test_disable_enable();
      test_zero_and_range();
      test_reset_pending();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
